// File: rtl/io_irq_ctrl8_if.sv
// IO byte-register bus plus CPU interrupt req/ack/EOI handshake for io_irq_ctrl8.
// master = CPU/bus side, slave = interrupt controller.
interface io_irq_ctrl8_if;
   logic [15:0] AIoAddr;
   logic [63:0] AIoMosi;
   logic [63:0] AIoMiso;
   logic [3:0]  AIoWrSize;
   logic [3:0]  AIoRdSize;
   logic        AIoAddrAck;
   logic        AIoAddrErr;
   logic        ACpuIrqReq;
   logic [2:0]  ACpuIrqVec;
   logic        ACpuIrqAck;
   logic        ACpuIrqEoi;

   modport master (
      output AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, ACpuIrqAck, ACpuIrqEoi,
      input  AIoMiso, AIoAddrAck, AIoAddrErr, ACpuIrqReq, ACpuIrqVec
   );

   modport slave (
      input  AIoAddr, AIoMosi, AIoWrSize, AIoRdSize, ACpuIrqAck, ACpuIrqEoi,
      output AIoMiso, AIoAddrAck, AIoAddrErr, ACpuIrqReq, ACpuIrqVec
   );
endinterface

// File: rtl/io_irq_ctrl8.sv
// 8-source priority interrupt controller; edge to request in 2 cycles, vector held until ack or withdraw.
// CPU backpressure is the ack; optional level-sensitive sources via IO_IRQ_CTRL_LEVEL_EN.
module io_irq_ctrl8 #(
   parameter logic [15:0] CAddrBase = 16'h0000
) (
   input  logic          AClkH,
   input  logic          AResetHN,
   input  logic          AClkHEn,
   input  logic [7:0]    AIrqLine,
   output logic [7:0]    ATest,
   io_irq_ctrl8_if.slave io
);

   typedef enum logic [1:0] {SIdle = 2'd0, SReq = 2'd1} tState;

`ifdef IO_IRQ_CTRL_LEVEL_EN
   localparam logic [15:0] CMapSize = 16'd5;
`else
   localparam logic [15:0] CMapSize = 16'd4;
`endif

   tState      FState;
   logic [7:0] FMask, FPend, FInSvc, FLinePrev, FLevelSel;
   logic       FGlobEn, FReq;
   logic [2:0] FVec;

   logic [15:0] ioOff;
   logic        inMap, wrByte, rdByte, wrOther, rdOther, wrEn;
   logic [7:0]  wrDat, rdByteVal;
   logic [7:0]  lowSvc, allowed, elig, rise, vecBit, pendNext, svcNext;
   logic        candVld, ackTake;
   logic [2:0]  candIdx;
   logic        unusedMosi;

   assign ioOff   = io.AIoAddr - CAddrBase;
   assign inMap   = ioOff < CMapSize;
   assign wrByte  = io.AIoWrSize == 4'b0001;
   assign rdByte  = io.AIoRdSize == 4'b0001;
   assign wrOther = (io.AIoWrSize != 4'b0000) && !wrByte;
   assign rdOther = (io.AIoRdSize != 4'b0000) && !rdByte;
   assign wrEn    = inMap && wrByte;
   assign wrDat   = io.AIoMosi[7:0];
   assign unusedMosi = ^io.AIoMosi[63:8];

   assign io.AIoAddrAck = inMap && (wrByte || rdByte);
   assign io.AIoAddrErr = inMap && (wrOther || rdOther);

   always_comb begin
      rdByteVal = 8'h00;
      if (inMap && rdByte) begin
         case (ioOff[2:0])
            3'd0:    rdByteVal = FMask;
            3'd1:    rdByteVal = FPend;
            3'd2:    rdByteVal = FInSvc;
            3'd3:    rdByteVal = {7'b0, FGlobEn};
`ifdef IO_IRQ_CTRL_LEVEL_EN
            3'd4:    rdByteVal = FLevelSel;
`endif
            default: rdByteVal = 8'h00;
         endcase
      end
   end
   assign io.AIoMiso = {56'h0, rdByteVal};

   // Only sources strictly above the lowest in-service priority may interrupt it;
   // with nothing in service lowSvc is 0 and allowed wraps to all ones.
   assign lowSvc  = FInSvc & (~FInSvc + 8'd1);
   assign allowed = lowSvc - 8'd1;
   assign elig    = FPend & FMask & {8{FGlobEn}} & allowed;

   always_comb begin
      candVld = 1'b0;
      candIdx = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (elig[i]) begin
            candVld = 1'b1;
            candIdx = 3'(i);
         end
      end
   end

   assign rise    = AIrqLine & ~FLinePrev;
   assign ackTake = (FState == SReq) && io.ACpuIrqAck;
   assign vecBit  = 8'b1 << FVec;

   // Clears are applied before sets so a same-cycle edge always wins.
   always_comb begin
      pendNext = FPend;
      if (wrEn && ioOff == 16'd1)
         pendNext = pendNext & ~wrDat;
      if (ackTake)
         pendNext = pendNext & ~vecBit;
      if (wrEn && ioOff == 16'd3 && wrDat[7])
         pendNext = pendNext | FMask;
      pendNext = pendNext | rise;
`ifdef IO_IRQ_CTRL_LEVEL_EN
      pendNext = (pendNext & ~FLevelSel) | (FLinePrev & FLevelSel);
`endif
   end

   always_comb begin
      svcNext = FInSvc;
      if (io.ACpuIrqEoi)
         svcNext = FInSvc & ~lowSvc;
      if (ackTake)
         svcNext = svcNext | vecBit;
   end

   always_ff @(posedge AClkH) begin
      if (!AResetHN) begin
         FState    <= SIdle;
         FMask     <= 8'h00;
         FPend     <= 8'h00;
         FInSvc    <= 8'h00;
         FLinePrev <= 8'h00;
         FLevelSel <= 8'h00;
         FGlobEn   <= 1'b0;
         FReq      <= 1'b0;
         FVec      <= 3'd0;
      end else if (AClkHEn) begin
         FLinePrev <= AIrqLine;
         FPend     <= pendNext;
         FInSvc    <= svcNext;
         if (wrEn && ioOff == 16'd0)
            FMask <= wrDat;
         if (wrEn && ioOff == 16'd3)
            FGlobEn <= wrDat[0];
`ifdef IO_IRQ_CTRL_LEVEL_EN
         if (wrEn && ioOff == 16'd4)
            FLevelSel <= wrDat;
`endif
         case (FState)
            SIdle: begin
               if (candVld) begin
                  FVec   <= candIdx;
                  FReq   <= 1'b1;
                  FState <= SReq;
               end
            end
            SReq: begin
               if (ackTake || !elig[FVec]) begin
                  FReq   <= 1'b0;
                  FState <= SIdle;
               end
            end
            default: begin
               FReq   <= 1'b0;
               FState <= SIdle;
            end
         endcase
      end
   end

   assign io.ACpuIrqReq = FReq;
   assign io.ACpuIrqVec = FVec;
   assign ATest = {FState, FReq, FGlobEn, |FInSvc, FVec};

endmodule
